hc_mmio_responder: RTL

MMIO read responder and CSR shadow for HardCloud AFUs. It snoops host MMIO writes on CCI-P channel c0 to keep a readable copy of the DSM base, the control word and the buffer descriptors. It answers every host MMIO read on channel c2 with a fixed two-cycle latency, serving the DFH/AFU ID header, the CSR shadows, a datapath status word and an optional run-cycle counter. It sits beside the accelerator's read/write FSMs and is the only driver of c2 in the AFU.

---
 rtl/hc_mmio_responder_pkg.sv | 72 +++++++
 rtl/hc_mmio_responder_cycle_counter.sv | 17 +
 rtl/hc_mmio_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hc_mmio_responder_pkg.sv
// hc_mmio_responder_pkg: CCI-P MMIO types, HardCloud CSR map and MMIO decode helpers
package hc_mmio_responder_pkg;
    typedef logic [15:0] t_ccip_mmioAddr;
    typedef logic [1:0]  t_ccip_mmioLen;
    typedef logic [8:0]  t_ccip_tid;
    typedef logic [63:0] t_ccip_mmioData;

    typedef struct packed {
        t_ccip_mmioAddr address;
        t_ccip_mmioLen  length;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        t_ccip_mmioData      data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef enum logic [2:0] {HC_RD_IDLE, HC_RD_REQ, HC_RD_WAIT, HC_RD_DATA, HC_RD_DONE} t_rd_state;
    typedef enum logic [2:0] {HC_WR_IDLE, HC_WR_REQ, HC_WR_WAIT, HC_WR_DATA, HC_WR_DONE} t_wr_state;

    typedef struct packed {
        t_wr_state wr_state;
        t_rd_state rd_state;
        logic      done;
    } t_hc_status;

    localparam logic [15:0] HC_DFH         = 16'h000;
    localparam logic [15:0] HC_AFU_ID_L    = 16'h008;
    localparam logic [15:0] HC_AFU_ID_H    = 16'h010;
    localparam logic [15:0] HC_DSM_BASE    = 16'h110;
    localparam logic [15:0] HC_CONTROL     = 16'h118;
    localparam logic [15:0] HC_BUFFER_BASE = 16'h120;
    localparam logic [15:0] HC_STATUS      = 16'h140;
    localparam logic [15:0] HC_CYCLES      = 16'h148;
    localparam int          HC_BUFFER_SIZE = 2;
    localparam logic [31:0] HC_CONTROL_START = 32'h3;
    localparam logic [63:0] HC_DFH_WORD = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 40'h0};

    function automatic logic hc_dsm_sel(t_if_ccip_c0_Rx rx);
        return rx.mmioWrValid && rx.hdr.address == HC_DSM_BASE >> 2;
    endfunction

    function automatic logic hc_control_sel(t_if_ccip_c0_Rx rx);
        return rx.mmioWrValid && rx.hdr.address == HC_CONTROL >> 2;
    endfunction

    // bit 0: qword write inside the buffer region, bit 1: size field (else address field)
    function automatic logic [1:0] hc_buffer_sel(t_if_ccip_c0_Rx rx);
        return {rx.hdr.address[1], rx.mmioWrValid && rx.hdr.address >= HC_BUFFER_BASE >> 2 && !rx.hdr.address[0]};
    endfunction

    function automatic logic [13:0] hc_buffer_which(t_if_ccip_c0_Rx rx);
        return 14'((rx.hdr.address - (HC_BUFFER_BASE >> 2)) >> 2);
    endfunction

    function automatic logic hc_mmio_rd_sel(t_if_ccip_c0_Rx rx);
        return rx.mmioRdValid;
    endfunction
endpackage

// File: rtl/hc_mmio_responder_cycle_counter.sv
// hc_cycle_counter: 64-bit wrapping run-cycle counter with synchronous clear
module hc_cycle_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [63:0] count
);
    logic [63:0] r_count;

    // clear wins over enable so a restart always begins at zero
    always_ff @(posedge clk) begin
        r_count <= (reset || clear) ? '0 : r_count + (enable ? 64'd1 : 64'd0);
    end

    assign count = r_count;
endmodule

// File: rtl/hc_mmio_responder.sv
// hc_mmio_responder: CSR shadow and 2-cycle MMIO read responder; HC_CYCLE_COUNTER_EN adds the run-cycle counter at 0x148
module hc_mmio_responder
    import hc_mmio_responder_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0,
    parameter int          NUM_BUFFERS = HC_BUFFER_SIZE
) (
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccip_c0_Rx rx_c0,
    output t_if_ccip_c2_Tx tx_c2,
    input  logic           status_done,
    input  t_rd_state      status_rd_state,
    input  t_wr_state      status_wr_state
);
    logic [63:0]    r_dsm;
    logic [31:0]    r_control;
    logic [41:0]    r_buf_addr [NUM_BUFFERS];
    logic [31:0]    r_buf_size [NUM_BUFFERS];
    logic           r_s1_valid;
    t_ccip_tid      r_s1_tid;
    t_ccip_mmioAddr r_s1_addr;
    t_ccip_mmioLen  r_s1_len;
    t_if_ccip_c2_Tx r_tx;
    logic [1:0]     w_buf_sel;
    logic [13:0]    w_buf_which;
    logic [14:0]    w_qidx;
    logic [63:0]    w_buf_word;
    logic [63:0]    w_qword;
    logic [63:0]    w_rdata;
    t_hc_status     w_status;

    assign w_buf_sel   = hc_buffer_sel(rx_c0);
    assign w_buf_which = hc_buffer_which(rx_c0);
    assign w_qidx      = r_s1_addr[15:1];
    assign w_status    = {status_wr_state, status_rd_state, status_done};

`ifdef HC_CYCLE_COUNTER_EN
    logic [63:0] w_cycles;

    hc_cycle_counter u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (hc_control_sel(rx_c0) && rx_c0.data[31:0] == HC_CONTROL_START),
        .enable (r_control == HC_CONTROL_START && !status_done),
        .count  (w_cycles)
    );
`endif

    // shadow host CSR writes; buffer indices beyond NUM_BUFFERS simply match no slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dsm     <= '0;
            r_control <= '0;
            for (int k = 0; k < NUM_BUFFERS; k++) begin
                r_buf_addr[k] <= '0;
                r_buf_size[k] <= '0;
            end
        end else begin
            if (hc_dsm_sel(rx_c0)) r_dsm <= rx_c0.data;
            if (hc_control_sel(rx_c0)) r_control <= rx_c0.data[31:0];
            for (int k = 0; k < NUM_BUFFERS; k++) begin
                if (w_buf_sel[0] && w_buf_which == 14'(k)) begin
                    if (w_buf_sel[1]) r_buf_size[k] <= rx_c0.data[31:0];
                    else r_buf_addr[k] <= rx_c0.data[41:0];
                end
            end
        end
    end

    // stage 1: capture the read request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_tid   <= '0;
            r_s1_addr  <= '0;
            r_s1_len   <= '0;
        end else begin
            r_s1_valid <= hc_mmio_rd_sel(rx_c0);
            r_s1_tid   <= rx_c0.hdr.tid;
            r_s1_addr  <= rx_c0.hdr.address;
            r_s1_len   <= rx_c0.hdr.length;
        end
    end

    // select the addressed qword; fixed CSRs take precedence over the buffer window
    always_comb begin
        w_buf_word = '0;
        for (int k = 0; k < NUM_BUFFERS; k++) begin
            if (w_qidx == 15'((HC_BUFFER_BASE >> 3) + 2 * k)) w_buf_word = 64'(r_buf_addr[k]);
            if (w_qidx == 15'((HC_BUFFER_BASE >> 3) + 2 * k + 1)) w_buf_word = 64'(r_buf_size[k]);
        end
        case (w_qidx)
            15'(HC_DFH >> 3):      w_qword = HC_DFH_WORD;
            15'(HC_AFU_ID_L >> 3): w_qword = AFU_ID_L;
            15'(HC_AFU_ID_H >> 3): w_qword = AFU_ID_H;
            15'(HC_DSM_BASE >> 3): w_qword = r_dsm;
            15'(HC_CONTROL >> 3):  w_qword = 64'(r_control);
            15'(HC_STATUS >> 3):   w_qword = 64'(w_status);
`ifdef HC_CYCLE_COUNTER_EN
            15'(HC_CYCLES >> 3):   w_qword = w_cycles;
`endif
            default:               w_qword = w_buf_word;
        endcase
        w_rdata = (r_s1_len == 2'd0) ? {32'h0, r_s1_addr[0] ? w_qword[63:32] : w_qword[31:0]} : w_qword;
    end

    // stage 2: register the response onto c2
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx <= '0;
        end else begin
            r_tx.mmioRdValid <= r_s1_valid;
            r_tx.hdr.tid     <= r_s1_tid;
            r_tx.data        <= w_rdata;
        end
    end

    assign tx_c2 = r_tx;
endmodule
